// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_t       : controller states IDLE / MULT / DIV / DONE
//   WIDTH_DEFAULT : operand and result width (only 32 is supported)
//   ITERATIONS    : number of datapath iterations per operation
//   LAST_ITER     : counter value on which the final iteration happens
//   INT_MIN       : most negative 32-bit two's-complement value
//   abs_val()     : magnitude of a signed operand, returned as unsigned
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WIDTH_DEFAULT = 32;
    localparam int ITERATIONS    = 32;
    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);
    localparam logic [WIDTH_DEFAULT-1:0] INT_MIN = 32'h8000_0000;

    // INT_MIN maps onto itself, which is the correct unsigned magnitude 2^31.
    function automatic logic [WIDTH_DEFAULT-1:0] abs_val(input logic [WIDTH_DEFAULT-1:0] v);
        return v[WIDTH_DEFAULT-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the Booth multiply and the
// restoring divide datapaths.
//   a, b : operands, already extended to WIDTH+1 bits by the caller
//   sub  : 1 selects a - b, 0 selects a + b
//   sum  : WIDTH+1-bit result
module multdiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply / divide unit.
// Multiply uses radix-2 Booth on a 65-bit product register; divide uses
// restoring division on operand magnitudes with the quotient sign fixed
// at the end. Each operation takes 32 iterations.
//   clock          : master clock, rising edge
//   reset          : asynchronous, active-low
//   ctrl_MULT      : start pulse for a signed multiply
//   ctrl_DIV       : start pulse for a signed divide
//   data_operandA  : multiplicand / dividend, sampled on a start edge
//   data_operandB  : multiplier / divisor, sampled on a start edge
//   data_result    : registered result, held until the next completion
//   data_exception : registered overflow / divide-by-zero flag
//   data_resultRDY : one-cycle completion pulse
//   busy           : high while iterating
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t           state;
    logic [4:0]       counter;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2*WIDTH:0] prod;

    logic             start_mult;
    logic             start_div;
    logic [WIDTH:0]   as_a;
    logic [WIDTH:0]   as_b;
    logic             as_sub;
    logic [WIDTH:0]   as_sum;
    logic [WIDTH:0]   hi_ext;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   booth_hi;
    logic [2*WIDTH:0] prod_next;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;

    // Exactly one start line high is a valid start; both high is ignored.
    assign start_mult = ctrl_MULT & ~ctrl_DIV;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;

    multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .sum (as_sum)
    );

    // In MULT the product register is {hi, multiplier, q_-1}; in DIV it is
    // {remainder (WIDTH+1 bits), quotient/dividend (WIDTH bits)}.
    always_comb begin
        hi_ext     = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        r_shift    = prod[2*WIDTH-1:WIDTH-1];
        as_a       = hi_ext;
        as_b       = {op_a[WIDTH-1], op_a};
        as_sub     = (prod[1:0] == 2'b10);
        booth_hi   = hi_ext;
        prod_next  = prod;
        quotient   = '0;
        fin_result = '0;
        fin_exc    = 1'b0;

        if (state == DIV) begin
            as_a   = r_shift;
            as_b   = {1'b0, abs_val(op_b)};
            as_sub = 1'b1;
            // A negative trial difference means the divisor did not fit: restore.
            if (as_sum[WIDTH])
                prod_next = {r_shift, prod[WIDTH-2:0], 1'b0};
            else
                prod_next = {as_sum, prod[WIDTH-2:0], 1'b1};
            quotient = prod_next[WIDTH-1:0];
            if (op_b == '0) begin
                fin_result = '0;
                fin_exc    = 1'b1;
            end else if (op_a == INT_MIN && op_b == '1) begin
                fin_result = INT_MIN;
                fin_exc    = 1'b1;
            end else begin
                fin_result = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? (~quotient + 1'b1) : quotient;
                fin_exc    = 1'b0;
            end
        end else begin
            // Booth pair 01 adds the multiplicand, 10 subtracts it, 00/11 skip.
            if (prod[1] ^ prod[0])
                booth_hi = as_sum;
            prod_next  = {booth_hi, prod[WIDTH:1]};
            fin_result = prod_next[WIDTH:1];
            fin_exc    = (prod_next[2*WIDTH:WIDTH+1] != {WIDTH{prod_next[WIDTH]}});
        end
    end

    // Controller: a valid start always wins, aborting any operation in
    // flight without a completion pulse; results are captured on the edge
    // of the final iteration so they appear together with the RDY pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            counter        <= 5'd0;
            op_a           <= '0;
            op_b           <= '0;
            prod           <= '0;
            busy           <= 1'b0;
            data_resultRDY <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start_mult || start_div) begin
                op_a    <= data_operandA;
                op_b    <= data_operandB;
                counter <= 5'd0;
                busy    <= 1'b1;
                if (start_mult) begin
                    prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                    state <= MULT;
                end else begin
                    prod  <= {{(WIDTH+1){1'b0}}, abs_val(data_operandA)};
                    state <= DIV;
                end
            end else begin
                case (state)
                    MULT, DIV: begin
                        prod <= prod_next;
                        if (counter == LAST_ITER) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result    <= fin_result;
                            data_exception <= fin_exc;
                        end else begin
                            counter <= counter + 5'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed operations push their
// expected result, exception and completion cycle into a scoreboard; a
// monitor pops and compares whenever data_resultRDY is seen.
module tb_multdiv_unit;

    typedef struct {
        logic [31:0] result;
        logic        exc;
        int          cycle;
    } expect_t;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    expect_t     sb[$];
    int          checks;
    int          errors;
    int          cycle_cnt;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle index; a start at index s completes at index s+32.
    initial cycle_cnt = 0;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    // Issues one start pulse; when push is set the expected completion is
    // queued for the monitor.
    task automatic applyStimulus(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                 input logic push, input logic [31:0] exp_res, input logic exp_exc);
        expect_t e;
        @(negedge clock);
        ctrl_MULT     = is_mult;
        ctrl_DIV      = ~is_mult;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        if (push) begin
            e.result = exp_res;
            e.exc    = exp_exc;
            e.cycle  = cycle_cnt + 32;
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL completion_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: every RDY pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        expect_t e;
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rdy: got RDY with result 0x%08h expected no RDY (cycle %0d)", data_result, cycle_cnt);
            end else begin
                e = sb.pop_front();
                checkOutput("result", data_result, e.result);
                checkOutput("exception", {31'b0, data_exception}, {31'b0, e.exc});
                checkOutput("rdy_cycle", 32'(cycle_cnt), 32'(e.cycle));
            end
        end
    end

    initial begin
        int busy_cycles;
        checks        = 0;
        errors        = 0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        reset         = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_result", data_result, 32'h0);
        checkOutput("reset_exception", {31'b0, data_exception}, 32'h0);
        checkOutput("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b1;

        // 7 x -6, with busy counted across the whole operation.
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFD6, 1'b0);
        busy_cycles = 0;
        repeat (34) begin
            @(negedge clock);
            if (busy) busy_cycles++;
        end
        checkOutput("busy_cycles", 32'(busy_cycles), 32'd32);
        waitIdle();

        // Both start lines high must be ignored.
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        @(negedge clock);
        checkOutput("both_high_busy", {31'b0, busy}, 32'h0);
        checkOutput("both_high_result", data_result, 32'hFFFF_FFD6);

        applyStimulus(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 32'hFFFF_FFEF, 32'd5, 1'b1, 32'hFFFF_FFFD, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 32'd100, 32'd0, 1'b1, 32'h0000_0000, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        waitIdle();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1'b0);
        waitIdle();

        // MULT 3x3 aborted at cycle 10 by DIV 9/3; outputs keep 7/-2 result.
        applyStimulus(1'b1, 32'd3, 32'd3, 1'b0, 32'h0, 1'b0);
        repeat (9) @(posedge clock);
        applyStimulus(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0);
        checkOutput("abort_held_result", data_result, 32'hFFFF_FFFD);
        checkOutput("abort_held_exception", {31'b0, data_exception}, 32'h0);
        waitIdle();

        // Restart arriving during DONE: both completions must pulse.
        applyStimulus(1'b1, 32'd5, 32'd6, 1'b1, 32'd30, 1'b0);
        repeat (32) @(posedge clock);
        applyStimulus(1'b0, 32'd20, 32'd4, 1'b1, 32'd5, 1'b0);
        waitIdle();

        // Reset in the middle of a multiply discards it completely.
        applyStimulus(1'b1, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midreset_result", data_result, 32'h0);
        checkOutput("midreset_exception", {31'b0, data_exception}, 32'h0);
        checkOutput("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
        checkOutput("midreset_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("post_reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("post_reset_result", data_result, 32'h0);

        applyStimulus(1'b1, 32'd2, 32'd2, 1'b1, 32'd4, 1'b0);
        waitIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; only 32 is supported.
REQ-002 clock  in  1  master clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ctrl_MULT  in  1  single-cycle start pulse for a signed multiply.
REQ-005 ctrl_DIV  in  1  single-cycle start pulse for a signed divide.
REQ-006 data_operandA  in  WIDTH  multiplicand or dividend; sampled only on a start edge.
REQ-007 data_operandB  in  WIDTH  multiplier or divisor; sampled only on a start edge.
REQ-008 data_result  out  WIDTH  registered result; held until the next op completes.
REQ-009 data_exception  out  1  registered exception flag; valid when data_resultRDY is high, held with data_result.
REQ-010 data_resultRDY  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high while an operation is in progress.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, MULT, DIV and DONE.
REQ-013 Start edge, exactly one ctrl line high:
- SHALL latch both operands.
- SHALL clear the iteration counter.
- SHALL enter MULT or DIV.
REQ-014 Start edge with ctrl_MULT and ctrl_DIV both high: SHALL be ignored, with no state change.
REQ-015 MULT/DIV SHALL perform one iteration per edge; the edge on which counter==31 SHALL enter DONE, giving 32 iterations.
REQ-016 DONE:
- data_resultRDY SHALL be 1 for exactly one cycle.
- The next edge SHALL return to IDLE.
- Result and exception SHALL be registered on entry to DONE.
REQ-017 Latency: data_resultRDY SHALL be high in the cycle beginning 32 rising edges after the start edge.
REQ-018 busy SHALL be 1 in MULT and DIV, and 0 in IDLE and DONE.
REQ-019 Multiply:
- SHALL use radix-2 Booth on a 2*WIDTH+1-bit product register.
- data_result SHALL be the low WIDTH bits.
REQ-020 Multiply exception: data_exception SHALL be 1 iff the true signed product is outside the range -2^31..2^31-1.
REQ-021 Divide:
- SHALL use restoring division on magnitudes.
- The quotient SHALL truncate toward zero and be negated when operand signs differ.
- The remainder SHALL be discarded.
REQ-022 Divide by zero: data_result SHALL be 0 and data_exception SHALL be 1.
REQ-023 0x80000000 / 0xFFFFFFFF: data_result SHALL be 0x80000000 and data_exception SHALL be 1.
REQ-024 A valid start edge while in MULT, DIV or DONE:
- SHALL abort the current operation and restart with the new operands.
- The aborted operation SHALL produce no data_resultRDY pulse.
- data_result and data_exception SHALL keep their prior values.
REQ-025 A start edge arriving in DONE SHALL still let the DONE-cycle data_resultRDY pulse of the completed op occur.

Reset
REQ-026 Asserting reset (low) SHALL immediately force:
- state IDLE, counter 0, busy 0;
- data_resultRDY 0, data_result 0, data_exception 0;
- internal operand and product registers 0.
REQ-027 Reset mid-operation SHALL discard the operation; no data_resultRDY pulse SHALL follow deassertion.
REQ-028 Start pulses SHALL be honoured from the first rising edge after reset is released.

Structure
REQ-029 Package multdiv_pkg SHALL hold:
- the state enumeration IDLE/MULT/DIV/DONE;
- the WIDTH default;
- the iteration count 32;
- constant INT_MIN = 0x80000000.
REQ-030 A single sub-module multdiv_addsub SHALL provide a (WIDTH+1)-bit adder/subtractor shared by the Booth and restoring-divide datapaths.
REQ-031 The counter SHALL be 5 bits, wrap-free, and reset on every start.

Verification
REQ-032 MULT 7 x -6:
- result 0xFFFFFFD6 (-42), exception 0;
- RDY exactly 32 cycles after the start edge;
- busy high for 32 cycles.
REQ-033 MULT 0x00010000 x 0x00010000: result 0x00000000, exception 1.
REQ-034 DIV -17 / 5: result 0xFFFFFFFD (-3), exception 0.
REQ-035 DIV 100 / 0: result 0, exception 1.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
REQ-037 MULT 3x3 restarted at cycle 10 with DIV 9/3:
- single RDY pulse 32 cycles after the second start;
- result 3, exception 0.
REQ-038 MULT started, reset low at cycle 5 for 2 cycles:
- all outputs 0 and no RDY afterwards;
- a following MULT 2x2 returns 4.
